nearest_centroid_select: RTL and testbench
==========================================

Name: nearest_centroid_select

Overview:
Sits directly downstream of distance_core in the K-means hardware accelerator. Consumes the stream of per-dimension squared differences over the stb/ack handshake, sums them per centroid, and tracks the running minimum. Presents the index and total squared distance of the nearest centroid to the cluster-assignment logic.

Parameters:
DIMS, 2, dimensions per point; squared-difference terms summed per centroid (>=1)
CLUSTERS, 4, centroids compared per point (>=1)
IDX_W, 8, width of the centroid index output; must satisfy CLUSTERS <= 2^IDX_W

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a new point; sampled only in idle
dist_stb  input  1  distance_core result valid
dist_z  input  64  distance_core squared difference (unsigned)
dist_ack  output  1  one-cycle pulse consuming dist_z
ack  input  1  downstream has taken the result
stb  output  1  result valid, held until ack
index  output  IDX_W  index of nearest centroid
min_dist  output  64  summed squared distance of nearest centroid

Behaviour:
- Reset (reset=0, asynchronous): state=idle; stb=0, dist_ack=0, index=0, min_dist=0; accumulator, dim and centroid counters cleared. Reset mid-operation aborts the point; no partial result is ever strobed.
- States: idle, read_dist, ack_dist, compare, wait_for_ack.
- idle: when start=1, clear stb, clear the accumulator, set dim_cnt=0 and cent_cnt=0, go to read_dist. Otherwise stay.
- read_dist: when dist_stb=1, do acc <= sat(acc + dist_z) and dist_ack <= 1, then go to ack_dist. Otherwise stay (no timeout).
- ack_dist (exactly 1 cycle): dist_ack <= 0. dist_stb is ignored here because upstream still drives it high this cycle.
  - If dim_cnt == DIMS-1, go to compare.
  - Else dim_cnt++ and return to read_dist.
- Arrival order is centroid-major: c0 dims 0..DIMS-1, then c1, and so on.
- Saturating add: if the 65-bit sum exceeds 2^64-1, acc = 64'hFFFF_FFFF_FFFF_FFFF. Once saturated, acc stays saturated for the rest of that centroid.
- compare (1 cycle):
  - If cent_cnt==0 or acc < min_dist (strict), load min_dist<=acc and index<=cent_cnt. Ties keep the lower index.
  - Then clear acc and set dim_cnt=0.
  - If cent_cnt == CLUSTERS-1, set stb<=1 and go to wait_for_ack. Else cent_cnt++ and go to read_dist.
- wait_for_ack: stb, index and min_dist are held stable.
  - On ack=1: stb <= 0, go to idle.
  - start asserted in any non-idle state is ignored and not queued.
  - index and min_dist keep their values after ack, until the next compare of a new point.
- Throughput: at least 2 cycles per term plus 1 compare cycle per centroid. With zero upstream latency, stb rises CLUSTERS*(2*DIMS+1)+1 cycles after start is sampled.
- dist_ack is never high for two consecutive cycles. dist_ack is never asserted in idle, compare or wait_for_ack.

Test Plan:
1. Basic argmin. DIMS=2, CLUSTERS=4, terms c0{9,16} c1{1,4} c2{25,0} c3{3,3} -> stb=1, index=1, min_dist=5. Exactly 8 dist_ack pulses, each 1 cycle wide.
2. Tie. Terms c0{2,2} c1{1,3} c2{4,0} c3{10,10} -> index=0, min_dist=4 (strict less keeps the first).
3. Saturation. c0{64'hFFFF_FFFF_FFFF_FFF0, 64'h20}, rest {7,0} -> c0 accumulates to all-ones. Result index=1, min_dist=7.
4. Handshake stalls. Upstream delays dist_stb by random 0-10 cycles; downstream holds ack=0 for 20 cycles. Check:
   - stb and outputs stay stable throughout.
   - start pulsed during the wait is ignored.
   - stb falls 1 cycle after ack.
   - The next start begins a fresh point with index=3 for terms where c3 is smallest.
5. Reset mid-point. Assert reset=0 after 3 terms -> stb=0, dist_ack=0, index=0, min_dist=0 immediately (asynchronous). After release, a full point from scenario 1 yields index=1, min_dist=5.
6. Edge configuration. DIMS=1, CLUSTERS=1, single term 42 -> index=0, min_dist=42, stb 4 cycles after start.

Source files
------------

// File: rtl/nearest_centroid_select.sv
// Sums DIMS squared-difference terms per centroid and tracks the nearest centroid (argmin, ties keep lower index).
// Latency CLUSTERS*(2*DIMS+1)+1 cycles from start at zero upstream latency; waits on dist_stb, holds result until ack.
module nearest_centroid_select #(
  parameter int DIMS     = 2,
  parameter int CLUSTERS = 4,
  parameter int IDX_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dist_stb,
  input  logic [63:0]       dist_z,
  output logic              dist_ack,
  input  logic              ack,
  output logic              stb,
  output logic [IDX_W-1:0]  index,
  output logic [63:0]       min_dist
);

  localparam int DIM_W  = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int CENT_W = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1;
  localparam logic [DIM_W-1:0]  DIM_LAST  = DIM_W'(DIMS - 1);
  localparam logic [CENT_W-1:0] CENT_LAST = CENT_W'(CLUSTERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_DIST,
    ACK_DIST,
    COMPARE,
    WAIT_FOR_ACK
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [63:0]         acc;
  logic [DIM_W-1:0]    dim_cnt;
  logic [CENT_W-1:0]   cent_cnt;
  logic [64:0]         sum;
  logic                take_min;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (start) state_nxt = READ_DIST;
      READ_DIST:    if (dist_stb) state_nxt = ACK_DIST;
      ACK_DIST:     state_nxt = (dim_cnt == DIM_LAST) ? COMPARE : READ_DIST;
      COMPARE:      state_nxt = (cent_cnt == CENT_LAST) ? WAIT_FOR_ACK : READ_DIST;
      WAIT_FOR_ACK: if (ack) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // dist_ack lives only in ACK_DIST, so it can never stretch past one cycle
  always_comb begin
    dist_ack = (state == ACK_DIST);
    stb      = (state == WAIT_FOR_ACK);
  end

  assign sum      = {1'b0, acc} + {1'b0, dist_z};
  assign take_min = (cent_cnt == '0) || (acc < min_dist);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      dim_cnt  <= '0;
      cent_cnt <= '0;
      index    <= '0;
      min_dist <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            dim_cnt  <= '0;
            cent_cnt <= '0;
          end
        end
        READ_DIST: begin
          // an all-ones accumulator overflows on any nonzero term, so saturation sticks
          if (dist_stb) acc <= sum[64] ? '1 : sum[63:0];
        end
        ACK_DIST: begin
          if (dim_cnt != DIM_LAST) dim_cnt <= dim_cnt + DIM_W'(1);
        end
        COMPARE: begin
          if (take_min) begin
            min_dist <= acc;
            index    <= IDX_W'(cent_cnt);
          end
          acc     <= '0;
          dim_cnt <= '0;
          if (cent_cnt != CENT_LAST) cent_cnt <= cent_cnt + CENT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nearest_centroid_select.sv
// Directed bench for nearest_centroid_select: vector table on a DIMS=2/CLUSTERS=4 instance plus
// hand sequences for stalls, mid-point reset and a DIMS=1/CLUSTERS=1 instance.
module tb_nearest_centroid_select;

  localparam int DIMS     = 2;
  localparam int CLUSTERS = 4;
  localparam int IDX_W    = 8;
  localparam int NT       = DIMS * CLUSTERS;
  localparam int LAT      = CLUSTERS * (2 * DIMS + 1) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              dist_stb = 1'b0;
  logic [63:0]       dist_z = '0;
  logic              ack = 1'b0;
  logic              dist_ack;
  logic              stb;
  logic [IDX_W-1:0]  index;
  logic [63:0]       min_dist;

  logic              start1 = 1'b0;
  logic              dist_stb1 = 1'b0;
  logic [63:0]       dist_z1 = '0;
  logic              ack1 = 1'b0;
  logic              dist_ack1;
  logic              stb1;
  logic [IDX_W-1:0]  index1;
  logic [63:0]       min_dist1;

  nearest_centroid_select #(.DIMS(DIMS), .CLUSTERS(CLUSTERS), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset), .start(start), .dist_stb(dist_stb), .dist_z(dist_z),
    .dist_ack(dist_ack), .ack(ack), .stb(stb), .index(index), .min_dist(min_dist)
  );

  nearest_centroid_select #(.DIMS(1), .CLUSTERS(1), .IDX_W(IDX_W)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .dist_stb(dist_stb1), .dist_z(dist_z1),
    .dist_ack(dist_ack1), .ack(ack1), .stb(stb1), .index(index1), .min_dist(min_dist1)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NT-1:0][63:0] terms;
    logic [IDX_W-1:0]    exp_idx;
    logic [63:0]         exp_min;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_err = 0;

  // Upstream model: presents queued terms, pops one per dist_ack, optional random gaps.
  logic [63:0] term_q [$];
  int          stall_max = 0;
  int          stall_cnt = 0;
  int          ack_pulses = 0;
  logic        prev_ack = 1'b0;
  logic        ack_double = 1'b0;
  logic        ack_with_stb = 1'b0;

  always @(negedge clock) begin
    if (dist_ack) begin
      ack_pulses++;
      if (prev_ack) ack_double = 1'b1;
      if (stb) ack_with_stb = 1'b1;
      if (term_q.size() > 0) term_q.delete(0);
      if (stall_max > 0) stall_cnt = int'($urandom_range(stall_max, 0));
      else stall_cnt = 0;
    end
    prev_ack = dist_ack;
    if (stall_cnt > 0) begin
      dist_stb = 1'b0;
      stall_cnt--;
    end else if (term_q.size() > 0) begin
      dist_stb = 1'b1;
      dist_z   = term_q[0];
    end else begin
      dist_stb = 1'b0;
      dist_z   = '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] a0, a1, b0, b1, c0, c1, d0, d1,
                              input int idx, input logic [63:0] mn);
    vec_t v;
    v.terms[0] = a0; v.terms[1] = a1;
    v.terms[2] = b0; v.terms[3] = b1;
    v.terms[4] = c0; v.terms[5] = c1;
    v.terms[6] = d0; v.terms[7] = d1;
    v.exp_idx  = IDX_W'(idx);
    v.exp_min  = mn;
    return v;
  endfunction

  task automatic run_point(input vec_t v, input int smax, input string tag, input bit do_ack);
    int cyc;
    stall_max  = smax;
    ack_pulses = 0;
    for (int i = 0; i < NT; i++) term_q.push_back(v.terms[i]);
    @(negedge clock);
    start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
      start = 1'b0;
    end while (!stb && cyc < 2000);
    chk({tag, " stb"}, 64'(stb), 64'd1);
    if (smax == 0) chk({tag, " latency"}, 64'(cyc), 64'(LAT));
    chk({tag, " index"}, 64'(index), 64'(v.exp_idx));
    chk({tag, " min_dist"}, min_dist, v.exp_min);
    chk({tag, " dist_ack pulses"}, 64'(ack_pulses), 64'(NT));
    if (do_ack) begin
      @(negedge clock);
      ack = 1'b1;
      @(posedge clock);
      #1;
      ack = 1'b0;
      chk({tag, " stb after ack"}, 64'(stb), 64'd0);
      chk({tag, " index kept"}, 64'(index), 64'(v.exp_idx));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_ok;
    int   cyc;
    int   acks1;

    vecs[0] = mk(9, 16, 1, 4, 25, 0, 3, 3, 1, 5);
    vecs[1] = mk(2, 2, 1, 3, 4, 0, 10, 10, 0, 4);
    vecs[2] = mk(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 7, 0, 7, 0, 7, 0, 1, 7);
    vecs[3] = mk(10, 10, 5, 6, 8, 1, 2, 2, 3, 4);
    vecs[4] = mk(100, 0, 0, 50, 49, 0, 0, 60, 2, 49);
    vecs[5] = mk(64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1,
                 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 0, 64'hFFFF_FFFF_FFFF_FFFF);

    repeat (2) @(negedge clock);
    chk("reset stb", 64'(stb), 64'd0);
    chk("reset dist_ack", 64'(dist_ack), 64'd0);
    chk("reset index", 64'(index), 64'd0);
    chk("reset min_dist", min_dist, 64'd0);
    reset = 1'b1;

    // Single-dimension, single-centroid instance
    dist_stb1 = 1'b1;
    dist_z1   = 64'd42;
    @(negedge clock);
    start1 = 1'b1;
    cyc = 0;
    acks1 = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
      start1 = 1'b0;
      if (dist_ack1) acks1++;
    end while (!stb1 && cyc < 50);
    chk("edge stb", 64'(stb1), 64'd1);
    chk("edge latency", 64'(cyc), 64'd4);
    chk("edge index", 64'(index1), 64'd0);
    chk("edge min_dist", min_dist1, 64'd42);
    chk("edge dist_ack pulses", 64'(acks1), 64'd1);
    @(negedge clock);
    ack1 = 1'b1;
    @(posedge clock);
    #1;
    ack1 = 1'b0;
    chk("edge stb after ack", 64'(stb1), 64'd0);
    dist_stb1 = 1'b0;

    for (int v = 0; v < 6; v++) run_point(vecs[v], 0, $sformatf("vec%0d", v), 1'b1);

    // Upstream gaps, then a long downstream stall with a stray start
    run_point(vecs[0], 10, "stall", 1'b0);
    for (int i = 0; i < NT; i++) term_q.push_back(vecs[3].terms[i]);
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      start = (c == 5);
      if (stb !== 1'b1 || index !== vecs[0].exp_idx || min_dist !== vecs[0].exp_min) hold_ok = 1'b0;
    end
    start = 1'b0;
    chk("stall outputs held", 64'(hold_ok), 64'd1);
    @(negedge clock);
    ack = 1'b1;
    @(posedge clock);
    #1;
    ack = 1'b0;
    chk("stall stb after ack", 64'(stb), 64'd0);
    ack_pulses = 0;
    repeat (40) @(posedge clock);
    #1;
    chk("stray start not queued", 64'(ack_pulses), 64'd0);
    chk("stray start no stb", 64'(stb), 64'd0);
    term_q.delete();
    run_point(vecs[3], 0, "fresh", 1'b1);

    // Asynchronous reset in the middle of a point
    stall_max  = 0;
    ack_pulses = 0;
    for (int i = 0; i < NT; i++) term_q.push_back(vecs[0].terms[i]);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 200 && ack_pulses < 3; c++) begin
      @(negedge clock);
      #1;
    end
    chk("midreset terms taken", 64'(ack_pulses), 64'd3);
    chk("midreset dist_ack live", 64'(dist_ack), 64'd1);
    chk("midreset min_dist live", min_dist, 64'd25);
    reset = 1'b0;
    #1;
    chk("midreset stb", 64'(stb), 64'd0);
    chk("midreset dist_ack", 64'(dist_ack), 64'd0);
    chk("midreset index", 64'(index), 64'd0);
    chk("midreset min_dist", min_dist, 64'd0);
    term_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    run_point(vecs[0], 0, "post-reset", 1'b1);

    chk("dist_ack back-to-back", 64'(ack_double), 64'd0);
    chk("dist_ack during stb", 64'(ack_with_stb), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
